// File: rtl/vfpu_dc_pkg.sv
// vfpu_dc_pkg: shared constants and types for the MAF timing model.
package vfpu_dc_pkg;
    localparam int ERR_CNT_W   = 16;
    localparam int MAF_LATENCY = 4;
    localparam int MAF_DATA_W  = 32;
    localparam int MAF_NUM_OPS = 3;
    typedef logic [MAF_NUM_OPS*MAF_DATA_W-1:0] maf_ops_t;
endpackage

// File: rtl/tm_dly_line.sv
// tm_dly_line: plain DEPTH-stage shift register with asynchronous reset to 0.
module tm_dly_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] stg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg <= '0;
        else begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
    end
    assign q = stg[DEPTH-1];
endmodule

// File: rtl/maf_tm_dly.sv
// maf_tm_dly: LATENCY-cycle operand/valid/tag delay with flush and in-flight count.
// Optional result-alignment checker enabled by MAF_TM_ALIGN_CHK_EN.
module maf_tm_dly
    import vfpu_dc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 3,
    parameter int LATENCY = MAF_LATENCY,
    parameter int TAG_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        op_vld,
    input  logic [NUM_OPS*DATA_W-1:0]   ops,
    input  logic                        flush,
    input  logic                        res_rdy,
    output logic                        op_vld_rx,
    output logic [NUM_OPS*DATA_W-1:0]   ops_rx,
    output logic [TAG_W-1:0]            tag_rx,
    output logic [$clog2(LATENCY+1)-1:0] inflight,
    output logic                        align_err,
    output logic [ERR_CNT_W-1:0]        err_cnt
);
    localparam int CNT_W = $clog2(LATENCY+1);
    localparam int LW    = 1 + TAG_W + NUM_OPS*DATA_W;

    logic             acc;
    logic             vld_q;
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] mask;

    assign acc = op_vld & ~flush;

    tm_dly_line #(.WIDTH(LW), .DEPTH(LATENCY)) u_line (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({acc, tag, ops}),
        .q     ({vld_q, tag_rx, ops_rx})
    );

    // Ops already in the line at a flush drain out over the next LATENCY-1 cycles; hide them.
    assign op_vld_rx = vld_q & (mask == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag      <= '0;
            mask     <= '0;
            inflight <= '0;
        end else begin
            tag      <= tag + TAG_W'(acc);
            mask     <= flush ? CNT_W'(LATENCY-1) : mask - CNT_W'(mask != '0);
            inflight <= flush ? '0 : inflight + CNT_W'(acc) - CNT_W'(op_vld_rx);
        end
    end

`ifdef MAF_TM_ALIGN_CHK_EN
    logic [CNT_W-1:0] blank;
    logic             miss;
    assign miss = ~flush & (blank == '0) & (res_rdy != op_vld_rx);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank     <= '0;
            align_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            blank     <= flush ? CNT_W'(LATENCY) : blank - CNT_W'(blank != '0);
            align_err <= align_err | miss;
            err_cnt   <= err_cnt + ERR_CNT_W'(miss & ~&err_cnt);
        end
    end
`else
    logic unused_res_rdy;
    assign unused_res_rdy = res_rdy;
    assign align_err      = 1'b0;
    assign err_cnt        = '0;
`endif
endmodule

// File: tb/tb_maf_tm_dly.sv
// tb_maf_tm_dly: randomized scoreboard bench for maf_tm_dly (default and TAG_W=2 instances).
module tb_maf_tm_dly;
    localparam int L = 4;

    typedef struct {
        logic [95:0] ops;
        int          tag;
        int          due;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        op_vld = 0;
    logic [95:0] ops = '0;
    logic        flush = 0;
    logic        res_rdy = 0;
    logic        op_vld_rx, op_vld_rx2;
    logic [95:0] ops_rx, ops_rx2;
    logic [7:0]  tag_rx;
    logic [1:0]  tag_rx2;
    logic [2:0]  inflight, inflight2;
    logic        align_err, align_err2;
    logic [15:0] err_cnt, err_cnt2;

    maf_tm_dly dut (
        .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .ops(ops), .flush(flush), .res_rdy(res_rdy),
        .op_vld_rx(op_vld_rx), .ops_rx(ops_rx), .tag_rx(tag_rx), .inflight(inflight),
        .align_err(align_err), .err_cnt(err_cnt)
    );

    maf_tm_dly #(.TAG_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .ops(ops), .flush(flush), .res_rdy(res_rdy),
        .op_vld_rx(op_vld_rx2), .ops_rx(ops_rx2), .tag_rx(tag_rx2), .inflight(inflight2),
        .align_err(align_err2), .err_cnt(err_cnt2)
    );

    initial forever #5 clk = ~clk;

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, tag_n = 0, last_flush = -1000, err_exp = 0, max_infl = 0;
    int   early_cyc = -1;
    bit   res_exp = 0, res_override = 0;
    exp_t q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int exp_errs();
`ifdef MAF_TM_ALIGN_CHK_EN
        return err_exp;
`else
        return 0;
`endif
    endfunction

    // Reference model: queue of accepted ops with their due cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            tag_n = 0;
            err_exp = 0;
            last_flush = -1000;
            res_exp = 0;
        end else begin
            if (flush) last_flush = cyc;
            if (!flush && cyc - last_flush > L && res_rdy != res_exp && err_exp < 65535) err_exp++;
            cyc++;
            if (flush) q.delete();
            else if (op_vld) begin
                q.push_back('{ops: ops, tag: tag_n, due: cyc + L - 1});
                tag_n++;
            end
            res_exp = q.size() != 0 && q[0].due == cyc;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_vld", {op_vld_rx, op_vld_rx2}, 0);
            chk("rst_ops", ops_rx, 0);
            chk("rst_tag", tag_rx, 0);
            chk("rst_infl", inflight, 0);
            chk("rst_err", {align_err, err_cnt}, 0);
        end else begin
            chk("inflight", inflight, q.size());
            chk("inflight2", inflight2, q.size());
            if (int'(inflight) > max_infl) max_infl = int'(inflight);
            if (q.size() != 0 && q[0].due == cyc) begin
                chk("vld", op_vld_rx, 1);
                chk("vld2", op_vld_rx2, 1);
                chk("ops", ops_rx, q[0].ops);
                chk("ops2", ops_rx2, q[0].ops);
                chk("tag", tag_rx, q[0].tag % 256);
                chk("tag2", tag_rx2, q[0].tag % 4);
                void'(q.pop_front());
            end else begin
                chk("vld_idle", op_vld_rx, 0);
                chk("vld2_idle", op_vld_rx2, 0);
            end
            chk("err_cnt", err_cnt, exp_errs());
            chk("align_err", align_err, exp_errs() != 0);
            chk("err_cnt2", err_cnt2, exp_errs());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        res_rdy = res_override ? (cyc == early_cyc) : res_exp;
    endtask

    task automatic drive(input bit v, input bit f, input logic [95:0] d);
        op_vld = v;
        flush  = f;
        ops    = d;
        tick();
    endtask

    function automatic logic [95:0] rnd();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        repeat (n) drive(0, 0, rnd());
    endtask

    initial begin
        repeat (3) drive(0, 0, '0);
        rst_n = 1;
        idle(2);
        drive(1, 0, {32'h3, 32'h2, 32'h1});
        idle(6);
        repeat (6) drive(1, 0, rnd());
        idle(6);
        chk("infl_peak", max_infl, 4);
        repeat (3) drive(1, 0, rnd());
        drive(1, 1, rnd());
        idle(6);
        drive(1, 0, rnd());
        idle(6);
        repeat (300) drive($urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, rnd());
        idle(6);
        drive(1, 0, rnd());
        drive(1, 0, rnd());
        #2 rst_n = 0;
        #1;
        chk("async_vld", op_vld_rx, 0);
        chk("async_ops", ops_rx, 0);
        chk("async_tag", tag_rx, 0);
        chk("async_infl", inflight, 0);
        idle(2);
        rst_n = 1;
        idle(8);
        early_cyc = cyc + L - 1;
        res_override = 1;
        drive(1, 0, rnd());
        idle(8);
        res_override = 0;
`ifdef MAF_TM_ALIGN_CHK_EN
        chk("chk_final", {align_err, err_cnt}, {1'b1, 16'd2});
`else
        chk("chk_final", {align_err, err_cnt}, 0);
`endif
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
